// File: rtl/decode_stage.sv
// RV32I decode stage: one-entry registered pipeline slot that turns a raw
// instruction word into an operation id, register indices and sign-extended immediate.
module decode_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [5:0]  instr_id,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  output logic [4:0]  rd_addr,
  output logic [31:0] imm,
  output logic [31:0] pc_out,
  output logic        illegal
);

  localparam logic [5:0] INSTR_NONE  = 6'd0;
  localparam logic [5:0] INSTR_LUI   = 6'd1;
  localparam logic [5:0] INSTR_AUIPC = 6'd2;
  localparam logic [5:0] INSTR_JAL   = 6'd3;
  localparam logic [5:0] INSTR_JALR  = 6'd4;
  localparam logic [5:0] INSTR_BEQ   = 6'd5;
  localparam logic [5:0] INSTR_BNE   = 6'd6;
  localparam logic [5:0] INSTR_BLT   = 6'd7;
  localparam logic [5:0] INSTR_BGE   = 6'd8;
  localparam logic [5:0] INSTR_BLTU  = 6'd9;
  localparam logic [5:0] INSTR_BGEU  = 6'd10;
  localparam logic [5:0] INSTR_LB    = 6'd11;
  localparam logic [5:0] INSTR_LH    = 6'd12;
  localparam logic [5:0] INSTR_LW    = 6'd13;
  localparam logic [5:0] INSTR_LBU   = 6'd14;
  localparam logic [5:0] INSTR_LHU   = 6'd15;
  localparam logic [5:0] INSTR_SB    = 6'd16;
  localparam logic [5:0] INSTR_SH    = 6'd17;
  localparam logic [5:0] INSTR_SW    = 6'd18;
  localparam logic [5:0] INSTR_ADDI  = 6'd19;
  localparam logic [5:0] INSTR_SLTI  = 6'd20;
  localparam logic [5:0] INSTR_SLTIU = 6'd21;
  localparam logic [5:0] INSTR_XORI  = 6'd22;
  localparam logic [5:0] INSTR_ORI   = 6'd23;
  localparam logic [5:0] INSTR_ANDI  = 6'd24;
  localparam logic [5:0] INSTR_SLLI  = 6'd25;
  localparam logic [5:0] INSTR_SRLI  = 6'd26;
  localparam logic [5:0] INSTR_SRAI  = 6'd27;
  localparam logic [5:0] INSTR_ADD   = 6'd28;
  localparam logic [5:0] INSTR_SUB   = 6'd29;
  localparam logic [5:0] INSTR_SLL   = 6'd30;
  localparam logic [5:0] INSTR_SLT   = 6'd31;
  localparam logic [5:0] INSTR_SLTU  = 6'd32;
  localparam logic [5:0] INSTR_XOR   = 6'd33;
  localparam logic [5:0] INSTR_SRL   = 6'd34;
  localparam logic [5:0] INSTR_SRA   = 6'd35;
  localparam logic [5:0] INSTR_OR    = 6'd36;
  localparam logic [5:0] INSTR_AND   = 6'd37;

  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OPIMM  = 7'h13;
  localparam logic [6:0] OPC_OP     = 7'h33;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] fmt_imm;
  logic [5:0]  dec_id;
  logic        dec_illegal;
  logic [31:0] dec_imm;
  logic        accept;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];

  assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                  in_instr[11:8], 1'b0};
  assign imm_u = {in_instr[31:12], 12'b0};
  assign imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                  in_instr[30:21], 1'b0};

  // Operation id selection; anything left at INSTR_NONE is an unsupported encoding.
  always_comb begin
    dec_id  = INSTR_NONE;
    fmt_imm = 32'b0;
    case (opcode)
      OPC_LUI:   begin dec_id = INSTR_LUI;   fmt_imm = imm_u; end
      OPC_AUIPC: begin dec_id = INSTR_AUIPC; fmt_imm = imm_u; end
      OPC_JAL:   begin dec_id = INSTR_JAL;   fmt_imm = imm_j; end
      OPC_JALR: begin
        fmt_imm = imm_i;
        if (funct3 == 3'd0) dec_id = INSTR_JALR;
      end
      OPC_BRANCH: begin
        fmt_imm = imm_b;
        case (funct3)
          3'd0: dec_id = INSTR_BEQ;
          3'd1: dec_id = INSTR_BNE;
          3'd4: dec_id = INSTR_BLT;
          3'd5: dec_id = INSTR_BGE;
          3'd6: dec_id = INSTR_BLTU;
          3'd7: dec_id = INSTR_BGEU;
          default: dec_id = INSTR_NONE;
        endcase
      end
      OPC_LOAD: begin
        fmt_imm = imm_i;
        case (funct3)
          3'd0: dec_id = INSTR_LB;
          3'd1: dec_id = INSTR_LH;
          3'd2: dec_id = INSTR_LW;
          3'd4: dec_id = INSTR_LBU;
          3'd5: dec_id = INSTR_LHU;
          default: dec_id = INSTR_NONE;
        endcase
      end
      OPC_STORE: begin
        fmt_imm = imm_s;
        case (funct3)
          3'd0: dec_id = INSTR_SB;
          3'd1: dec_id = INSTR_SH;
          3'd2: dec_id = INSTR_SW;
          default: dec_id = INSTR_NONE;
        endcase
      end
      OPC_OPIMM: begin
        // Shifts keep the whole I immediate; funct7 occupies imm[11:5] there.
        fmt_imm = imm_i;
        case (funct3)
          3'd0: dec_id = INSTR_ADDI;
          3'd2: dec_id = INSTR_SLTI;
          3'd3: dec_id = INSTR_SLTIU;
          3'd4: dec_id = INSTR_XORI;
          3'd6: dec_id = INSTR_ORI;
          3'd7: dec_id = INSTR_ANDI;
          3'd1: dec_id = (funct7 == 7'h00) ? INSTR_SLLI : INSTR_NONE;
          3'd5: begin
            if (funct7 == 7'h00)      dec_id = INSTR_SRLI;
            else if (funct7 == 7'h20) dec_id = INSTR_SRAI;
            else                      dec_id = INSTR_NONE;
          end
          default: dec_id = INSTR_NONE;
        endcase
      end
      OPC_OP: begin
        case ({funct7, funct3})
          {7'h00, 3'd0}: dec_id = INSTR_ADD;
          {7'h20, 3'd0}: dec_id = INSTR_SUB;
          {7'h00, 3'd1}: dec_id = INSTR_SLL;
          {7'h00, 3'd2}: dec_id = INSTR_SLT;
          {7'h00, 3'd3}: dec_id = INSTR_SLTU;
          {7'h00, 3'd4}: dec_id = INSTR_XOR;
          {7'h00, 3'd5}: dec_id = INSTR_SRL;
          {7'h20, 3'd5}: dec_id = INSTR_SRA;
          {7'h00, 3'd6}: dec_id = INSTR_OR;
          {7'h00, 3'd7}: dec_id = INSTR_AND;
          default:       dec_id = INSTR_NONE;
        endcase
      end
      default: begin
        dec_id  = INSTR_NONE;
        fmt_imm = 32'b0;
      end
    endcase
  end

  assign dec_illegal = (dec_id == INSTR_NONE);
  assign dec_imm     = dec_illegal ? 32'b0 : fmt_imm;

  // Handshake: in_ready = !out_valid || out_ready; accept = in_valid && in_ready.
  // out_valid holds the result until out_ready is seen high on a rising edge.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      illegal   <= 1'b0;
      instr_id  <= INSTR_NONE;
      rs1_addr  <= 5'b0;
      rs2_addr  <= 5'b0;
      rd_addr   <= 5'b0;
      imm       <= 32'b0;
      pc_out    <= 32'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      illegal   <= dec_illegal;
      instr_id  <= dec_id;
      rs1_addr  <= in_instr[19:15];
      rs2_addr  <= in_instr[24:20];
      rd_addr   <= in_instr[11:7];
      imm       <= dec_imm;
      pc_out    <= in_pc;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed spec vectors plus randomized handshake traffic
// checked against a table-driven reference decoder and a cycle model of the slot.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready, illegal;
  logic [31:0] in_instr, in_pc, imm, pc_out;
  logic [5:0]  instr_id;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .instr_id(instr_id), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
    .imm(imm), .pc_out(pc_out), .illegal(illegal)
  );

  typedef struct packed {
    logic        v;
    logic        ill;
    logic [5:0]  id;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [31:0] pc;
  } rec_t;

  // Supported encodings; the operation id is the table position plus one.
  // -1 marks a field that does not take part in selecting the operation.
  localparam int NTAB = 37;
  localparam int TAB_OP [NTAB] = '{
    'h37, 'h17, 'h6F, 'h67,
    'h63, 'h63, 'h63, 'h63, 'h63, 'h63,
    'h03, 'h03, 'h03, 'h03, 'h03,
    'h23, 'h23, 'h23,
    'h13, 'h13, 'h13, 'h13, 'h13, 'h13, 'h13, 'h13, 'h13,
    'h33, 'h33, 'h33, 'h33, 'h33, 'h33, 'h33, 'h33, 'h33, 'h33};
  localparam int TAB_F3 [NTAB] = '{
    -1, -1, -1, 0,
    0, 1, 4, 5, 6, 7,
    0, 1, 2, 4, 5,
    0, 1, 2,
    0, 2, 3, 4, 6, 7, 1, 5, 5,
    0, 0, 1, 2, 3, 4, 5, 5, 6, 7};
  localparam int TAB_F7 [NTAB] = '{
    -1, -1, -1, -1,
    -1, -1, -1, -1, -1, -1,
    -1, -1, -1, -1, -1,
    -1, -1, -1,
    -1, -1, -1, -1, -1, -1, 0, 0, 'h20,
    0, 'h20, 0, 0, 0, 0, 0, 'h20, 0, 0};

  localparam logic [5:0] ID_BEQ  = 6'd5;
  localparam logic [5:0] ID_ADDI = 6'd19;
  localparam logic [5:0] ID_SRAI = 6'd27;

  rec_t model;

  function automatic int sx(input int val, input int bits);
    if (val >= (1 << (bits - 1))) return val - (1 << bits);
    return val;
  endfunction

  function automatic rec_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
    rec_t r;
    int   op, f3, f7, found, iv;
    op = int'(w[6:0]);
    f3 = int'(w[14:12]);
    f7 = int'(w[31:25]);
    found = 0;
    for (int k = 0; k < NTAB; k++)
      if (TAB_OP[k] == op && (TAB_F3[k] < 0 || TAB_F3[k] == f3) &&
          (TAB_F7[k] < 0 || TAB_F7[k] == f7))
        found = k + 1;
    case (op)
      'h13, 'h03, 'h67: iv = sx(int'(w[31:20]), 12);
      'h23: iv = sx(int'(w[31:25]) * 32 + int'(w[11:7]), 12);
      'h63: iv = sx(int'(w[31]) * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32 +
                    int'(w[11:8]) * 2, 13);
      'h37, 'h17: iv = int'(w[31:12]) * 4096;
      'h6F: iv = sx(int'(w[31]) * (1 << 20) + int'(w[19:12]) * 4096 +
                    int'(w[20]) * 2048 + int'(w[30:21]) * 2, 21);
      default: iv = 0;
    endcase
    r.v   = 1'b1;
    r.ill = (found == 0);
    r.id  = 6'(found);
    r.rs1 = w[19:15];
    r.rs2 = w[24:20];
    r.rd  = w[11:7];
    r.imm = (found == 0) ? 32'd0 : 32'(iv);
    r.pc  = pc;
    return r;
  endfunction

  function automatic rec_t get_dut();
    rec_t r;
    r = '{out_valid, illegal, instr_id, rs1_addr, rs2_addr, rd_addr, imm, pc_out};
    return r;
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [31:0] w;
    int r, k;
    r = $urandom_range(0, 9);
    w = $urandom;
    if (r < 7) begin
      k = $urandom_range(0, NTAB - 1);
      w[6:0] = 7'(TAB_OP[k]);
      if (TAB_F3[k] >= 0) w[14:12] = 3'(TAB_F3[k]);
      if (TAB_F7[k] >= 0 && r != 6) w[31:25] = 7'(TAB_F7[k]);
    end
    return w;
  endfunction

  // Slot behaviour: reset wins, then flush, then load on accept, else drain on consume.
  task automatic tick();
    @(posedge clk);
    if (rst) model = '0;
    else if (flush) model.v = 1'b0;
    else if (in_valid && (!model.v || out_ready)) model = ref_decode(in_instr, in_pc);
    else if (out_ready) model.v = 1'b0;
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [31:0] w, input logic [31:0] pc,
                       input logic ordy, input logic fl);
    in_valid  = v;
    in_instr  = w;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic test_reset();
    rec_t d;
    rst = 1'b1;
    drive(1'b1, 32'h00500093, 32'h44, 1'b1, 1'b0);
    model = '0;
    tick();
    tick();
    d = get_dut();
    checks++;
    if (d !== rec_t'(0)) begin
      fails++;
      $display("FAIL reset_outputs: got %h expected %h", d, rec_t'(0));
    end
    rst = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_directed();
    rec_t d, lit;
    logic [31:0] words [4] = '{32'h00500093, 32'h40315213, 32'hFE208CE3, 32'hFFFFFFFF};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, words[i], 32'h100 + 32'(i * 4), 1'b1, 1'b0);
      tick();
      d = get_dut();
      checks++;
      if (d !== model) begin
        fails++;
        $display("FAIL directed_model[%0d]: got %h expected %h", i, d, model);
      end
      case (i)
        0: lit = '{1'b1, 1'b0, ID_ADDI, 5'd0, 5'd5, 5'd1, 32'h5, 32'h100};
        1: lit = '{1'b1, 1'b0, ID_SRAI, 5'd2, 5'd3, 5'd4, 32'h403, 32'h104};
        2: lit = '{1'b1, 1'b0, ID_BEQ, 5'd1, 5'd2, 5'd25, 32'hFFFFFFF8, 32'h108};
        default: lit = '{1'b1, 1'b1, 6'd0, 5'd31, 5'd31, 5'd31, 32'h0, 32'h10C};
      endcase
      checks++;
      if (d !== lit) begin
        fails++;
        $display("FAIL directed_literal[%0d]: got %h expected %h", i, d, lit);
      end
    end
  endtask

  task automatic test_stall();
    rec_t d, held;
    drive(1'b1, 32'h00500093, 32'h200, 1'b1, 1'b0);
    tick();
    held = ref_decode(32'h00500093, 32'h200);
    drive(1'b1, 32'h40315213, 32'h204, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
        fails++;
        $display("FAIL stall_in_ready[%0d]: got %b expected 0", c, in_ready);
      end
      tick();
      d = get_dut();
      checks++;
      if (d !== held) begin
        fails++;
        $display("FAIL stall_hold[%0d]: got %h expected %h", c, d, held);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL stall_release_ready: got %b expected 1", in_ready);
    end
    tick();
    d = get_dut();
    checks++;
    if (d !== ref_decode(32'h40315213, 32'h204)) begin
      fails++;
      $display("FAIL stall_release_load: got %h expected %h", d,
               ref_decode(32'h40315213, 32'h204));
    end
  endtask

  task automatic test_flush();
    rec_t d;
    drive(1'b1, 32'h00A00113, 32'h300, 1'b1, 1'b1);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL flush_in_ready: got %b expected 1", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_valid !== model.v) begin
      fails++;
      $display("FAIL flush_drop: got out_valid %b expected 0", out_valid);
    end
    // Load then stall, then reset mid-stall.
    drive(1'b1, 32'h00500093, 32'h304, 1'b1, 1'b0);
    tick();
    drive(1'b1, 32'h40315213, 32'h308, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    d = get_dut();
    checks++;
    if (d !== rec_t'(0)) begin
      fails++;
      $display("FAIL reset_mid_stall: got %h expected %h", d, rec_t'(0));
    end
  endtask

  task automatic test_back_to_back();
    rec_t d;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, gen_instr(), $urandom, 1'b1, 1'b0);
      tick();
      d = get_dut();
      checks++;
      if (d !== model || out_valid !== 1'b1) begin
        fails++;
        $display("FAIL back_to_back[%0d]: got %h expected %h", i, d, model);
      end
    end
  endtask

  task automatic test_random();
    rec_t d;
    for (int i = 0; i < 2000; i++) begin
      drive($urandom_range(0, 3) != 0, gen_instr(), $urandom,
            $urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0);
      rst = ($urandom_range(0, 49) == 0);
      #1;
      checks++;
      if (in_ready !== (!model.v || out_ready)) begin
        fails++;
        $display("FAIL random_in_ready[%0d]: got %b expected %b", i, in_ready,
                 !model.v || out_ready);
      end
      tick();
      d = get_dut();
      checks++;
      if (d !== model) begin
        fails++;
        $display("FAIL random_outputs[%0d]: got %h expected %h", i, d, model);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    model = '0;
    @(negedge clk);
    test_reset();
    test_directed();
    test_stall();
    test_flush();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock; single clock domain.
REQ-002 SHALL have port: rst  input  1  synchronous active-high reset, sampled on rising clk.
REQ-003 SHALL have port: flush  input  1  discard the held decode result (branch/trap redirect).
REQ-004 SHALL have port: in_valid  input  1  fetched instruction present.
REQ-005 SHALL have port: in_ready  output  1  stage can accept an instruction this cycle.
REQ-006 SHALL have port: in_instr  input  32  raw RV32I instruction word.
REQ-007 SHALL have port: in_pc  input  32  PC of in_instr.
REQ-008 SHALL have port: out_valid  output  1  decoded result held for the execute stage.
REQ-009 SHALL have port: out_ready  input  1  execute stage consumes the result this cycle.
REQ-010 SHALL have port: instr_id  output  6  operation code per instr_defines.vh (INSTR_ADD, INSTR_ADDI, INSTR_SRAI, INSTR_BEQ, ...); 0 = invalid.
REQ-011 SHALL have port: rs1_addr, rs2_addr, rd_addr  output  5 each  register indices.
REQ-012 SHALL have port: imm  output  32  sign-extended immediate.
REQ-013 SHALL have port: pc_out  output  32  registered in_pc.
REQ-014 SHALL have port: illegal  output  1  in_instr is not a supported RV32I encoding.

Function
REQ-015 SHALL implement a one-entry registered pipeline stage; accept = in_valid && in_ready.
REQ-016 SHALL drive in_ready = !out_valid || out_ready (combinational; no dependence on in_valid).
REQ-017 On accept, SHALL register all outputs from in_instr/in_pc with 1-cycle latency and set out_valid=1.
REQ-018 On out_valid && out_ready without accept, SHALL clear out_valid; other outputs hold their values.
REQ-019 With out_valid=1 and out_ready=0, SHALL hold every output stable.
REQ-020 Simultaneous consume and accept SHALL load the new instruction, with out_valid staying 1 and no bubble.
REQ-021 flush SHALL clear out_valid next cycle and take priority over accept; the instruction presented during flush is dropped, and in_ready is still computed per REQ-016.
REQ-022 Immediate formats: I = sext(instr[31:20]); S = sext({instr[31:25], instr[11:7]}); B = sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}); U = {instr[31:12], 12'b0}; J = sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}); R-type imm = 0.
REQ-023 Shift-immediates (SLLI/SRLI/SRAI) SHALL output the full I immediate; the consumer uses imm[4:0].
REQ-024 Opcode classes decoded: OP, OP-IMM, LOAD, STORE, BRANCH, LUI, AUIPC, JAL, JALR.
REQ-025 funct3/funct7 SHALL select the instr_id.
REQ-026 funct7 SHALL be 0x00, or 0x20 only for SUB/SRA/SRAI; any other funct7 is illegal.
REQ-027 Illegal or unknown encodings SHALL produce illegal=1, instr_id=0, and imm=0; they are still accepted and still set out_valid=1.
REQ-028 rs1/rs2/rd fields SHALL be output raw (instr[19:15], [24:20], [11:7]) regardless of format.

Reset
REQ-029 While rst=1, SHALL force out_valid=0, illegal=0, instr_id=0, imm=0, addresses=0, and pc_out=0; rst has priority over flush and accept.
REQ-030 After reset, in_ready SHALL be 1 in the first cycle rst=0.

Verification
REQ-031 in_instr=0x00500093, in_pc=0x100, out_ready=1 -> next cycle: instr_id=INSTR_ADDI, rd=1, rs1=0, imm=0x00000005, pc_out=0x100, illegal=0.
REQ-032 in_instr=0x40315213 -> instr_id=INSTR_SRAI, rd=4, rs1=2, imm=0x00000403 (imm[4:0]=3).
REQ-033 in_instr=0xFE208CE3 -> instr_id=INSTR_BEQ, rs1=1, rs2=2, imm=0xFFFFFFF8.
REQ-034 in_instr=0xFFFFFFFF -> out_valid=1, illegal=1, instr_id=0.
REQ-035 out_ready=0 for 3 cycles while holding ADDI, with a new instruction pending -> in_ready=0 and outputs unchanged; out_ready=1 -> new instruction appears next cycle with no bubble.
REQ-036 flush asserted in the same cycle as an accept -> out_valid=0 next cycle; rst asserted mid-stall -> all outputs zero next cycle.
